// File: rtl/stack_ram_arbiter.sv
// Two-port arbiter in front of the single-port stack/data RAM: port 0 = CPU core, port 1 = loader.
// Optional round-robin arbitration is enabled by defining RAM_ARB_RR_EN; the default is fixed priority.
module stack_ram_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address_ram,
    output logic [DATA_W-1:0] data_ram,
    output logic              wren_ram,
    input  logic [DATA_W-1:0] q_ram,
    output logic [2:0]        rd_pending
);

    // One tag slot per cycle from accept until the RAM returns the data.
    localparam int unsigned PipeDepth = RD_LAT + 1;

    logic              accept;
    logic              rd_accept;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic [PipeDepth-1:0] pipe_vld;
    logic [PipeDepth-1:0] pipe_tag;
    logic                 ret_vld;
    logic                 ret_tag;

`ifdef RAM_ARB_RR_EN
    // rr_ptr names the port that wins when both request.
    logic rr_ptr;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            gnt0 = ~rr_ptr;
            gnt1 = rr_ptr;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= 1'b0;
        end else if (gnt0) begin
            rr_ptr <= 1'b1;
        end else if (gnt1) begin
            rr_ptr <= 1'b0;
        end
    end
`else
    assign gnt0 = req0;
    assign gnt1 = req1 & ~req0;
`endif

    always_comb begin
        cmd_we    = we0;
        cmd_addr  = addr0;
        cmd_wdata = wdata0;
        if (gnt1) begin
            cmd_we    = we1;
            cmd_addr  = addr1;
            cmd_wdata = wdata1;
        end
    end

    assign accept    = gnt0 | gnt1;
    assign rd_accept = accept & ~cmd_we;

    // RAM pins are registered; address and data hold their last value when idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            address_ram <= '0;
            data_ram    <= '0;
            wren_ram    <= 1'b0;
        end else begin
            wren_ram <= accept & cmd_we;
            if (accept) begin
                address_ram <= cmd_addr;
                data_ram    <= cmd_wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= '0;
            pipe_tag <= '0;
        end else begin
            pipe_vld <= {pipe_vld[PipeDepth-2:0], rd_accept};
            pipe_tag <= {pipe_tag[PipeDepth-2:0], gnt1};
        end
    end

    assign ret_vld = pipe_vld[PipeDepth-1];
    assign ret_tag = pipe_tag[PipeDepth-1];

    assign rvalid0 = ret_vld & ~ret_tag;
    assign rvalid1 = ret_vld & ret_tag;
    assign rdata0  = rvalid0 ? q_ram : '0;
    assign rdata1  = rvalid1 ? q_ram : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending <= 3'd0;
        end else begin
            case ({rd_accept, ret_vld})
                2'b10:   rd_pending <= rd_pending + 3'd1;
                2'b01:   rd_pending <= rd_pending - 3'd1;
                default: rd_pending <= rd_pending;
            endcase
        end
    end

endmodule
